// File: rtl/contador_de_bits_param.sv
// Parametrised bit counter: captures a word, counts bits matching a selectable
// criterion LANES bits per cycle, and holds the count on a valid/ready output.
module contador_de_bits_param #(
    parameter int WIDTH = 8,
    parameter int LANES = 1,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       modo,
    output logic             read_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [CW-1:0]    data_out,
    output logic [1:0]       estados
);

    localparam int IW = $clog2(WIDTH + LANES + 1);
    localparam logic [WIDTH-1:0] LANE_MASK = {WIDTH{1'b1}} >> (WIDTH - LANES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] word;
    logic             target;
    logic             target_in;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    acc;
    logic [CW-1:0]    beat_sum;
    logic [WIDTH-1:0] window;
    logic [WIDTH-1:0] range_mask;
    logic             last_beat;

    // Modes 00/01 reduce to a constant target bit; 10/11 take it from the word.
    always_comb begin
        target_in = 1'b1;
        case (modo)
            2'b00:   target_in = 1'b1;
            2'b01:   target_in = 1'b0;
            2'b10:   target_in = data_in[WIDTH-1];
            default: target_in = data_in[0];
        endcase
    end

    // range_mask drops lane positions past the top of the word in the last beat.
    always_comb begin
        window     = word >> idx;
        range_mask = {WIDTH{1'b1}} >> idx;
        beat_sum   = CW'($countones((target ? window : ~window) & LANE_MASK & range_mask));
        last_beat  = (int'(idx) + LANES) >= WIDTH;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_in)  state_next = COUNT;
            COUNT:   if (last_beat) state_next = DONE;
            DONE:    if (ready_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word     <= '0;
            target   <= 1'b0;
            idx      <= '0;
            acc      <= '0;
            data_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        word   <= data_in;
                        target <= target_in;
                        acc    <= '0;
                        idx    <= '0;
                    end
                end
                COUNT: begin
                    acc <= acc + beat_sum;
                    idx <= idx + IW'(LANES);
                    if (last_beat) begin
                        data_out <= acc + beat_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_in   = (state == IDLE);
        valid_out = (state == DONE);
        estados   = state;
    end

endmodule

// File: tb/tb_contador_de_bits_param.sv
// Bench for contador_de_bits_param: two instances (LANES=1 and LANES=3, WIDTH=8)
// driven with directed and random words, checked against a popcount model.
module tb_contador_de_bits_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vin  [2];
    logic [7:0] din  [2];
    logic [1:0] mo   [2];
    logic       rdy  [2];
    logic       rin  [2];
    logic       vout [2];
    logic [3:0] dout [2];
    logic [1:0] est  [2];

    int    vectors = 0;
    int    errors  = 0;
    time   last_accept [2];

    always #5 clk = ~clk;

    contador_de_bits_param #(.WIDTH(8), .LANES(1)) u_l1 (
        .clk(clk), .reset(rst_n), .valid_in(vin[0]), .data_in(din[0]), .modo(mo[0]),
        .read_in(rin[0]), .valid_out(vout[0]), .ready_out(rdy[0]),
        .data_out(dout[0]), .estados(est[0])
    );

    contador_de_bits_param #(.WIDTH(8), .LANES(3)) u_l3 (
        .clk(clk), .reset(rst_n), .valid_in(vin[1]), .data_in(din[1]), .modo(mo[1]),
        .read_in(rin[1]), .valid_out(vout[1]), .ready_out(rdy[1]),
        .data_out(dout[1]), .estados(est[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int model(input logic [7:0] d, input logic [1:0] m);
        int ones;
        ones = $countones(d);
        case (m)
            2'b00:   return ones;
            2'b01:   return 8 - ones;
            2'b10:   return d[7] ? ones : 8 - ones;
            default: return d[0] ? ones : 8 - ones;
        endcase
    endfunction

    task automatic run_word(input int sel, input logic [7:0] d, input logic [1:0] m,
                            input int hold, input bit b2b);
        int  n;
        int  lat;
        int  w;
        bit  rd_ok;
        int  expv;
        n    = (sel == 0) ? 8 : 3;
        expv = model(d, m);
        rdy[sel] = (hold == 0);
        w = 0;
        while (rin[sel] !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("read_in_idle", 32'(rin[sel]), 32'd1);
        vin[sel] = 1'b1;
        din[sel] = d;
        mo[sel]  = m;
        @(posedge clk);
        if (b2b) check("spacing", 32'((($time - last_accept[sel]) / 10)), 32'(n + 2));
        last_accept[sel] = $time;
        @(negedge clk);
        vin[sel] = 1'b0;
        din[sel] = 8'($urandom);
        mo[sel]  = 2'($urandom);
        lat   = 0;
        rd_ok = 1'b1;
        while (vout[sel] !== 1'b1 && lat < 40) begin
            if (rin[sel] !== 1'b0) rd_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(n));
        check("read_in_low_busy", 32'(rd_ok), 32'd1);
        check("result", 32'(dout[sel]), 32'(expv));
        check("estados_done", 32'(est[sel]), 32'd2);
        for (int i = 0; i < hold; i++) begin
            vin[sel] = 1'b1;
            din[sel] = 8'($urandom);
            mo[sel]  = 2'($urandom);
            @(negedge clk);
            check("hold_valid_out", 32'(vout[sel]), 32'd1);
            check("hold_data_out", 32'(dout[sel]), 32'(expv));
            check("hold_read_in", 32'(rin[sel]), 32'd0);
        end
        vin[sel] = 1'b0;
        rdy[sel] = 1'b1;
        @(negedge clk);
        check("post_read_in", 32'(rin[sel]), 32'd1);
        check("post_valid_out", 32'(vout[sel]), 32'd0);
        check("post_estados", 32'(est[sel]), 32'd0);
        check("post_data_kept", 32'(dout[sel]), 32'(expv));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            vin[s] = 1'b0; din[s] = '0; mo[s] = '0; rdy[s] = 1'b0; last_accept[s] = 0;
        end
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst_estados", 32'(est[s]), 32'd0);
            check("rst_read_in", 32'(rin[s]), 32'd1);
            check("rst_valid_out", 32'(vout[s]), 32'd0);
            check("rst_data_out", 32'(dout[s]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int m = 0; m < 4; m++) run_word(0, 8'h07, 2'(m), 0, 1'b0);
        run_word(1, 8'hFF, 2'b00, 0, 1'b0);
        run_word(1, 8'h00, 2'b01, 0, 1'b0);
        run_word(0, 8'h3C, 2'b10, 5, 1'b0);
        run_word(1, 8'hC3, 2'b11, 5, 1'b0);

        // reset in the middle of an 8-cycle count
        rdy[0] = 1'b0;
        vin[0] = 1'b1; din[0] = 8'hFF; mo[0] = 2'b00;
        @(posedge clk);
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_estados", 32'(est[0]), 32'd0);
        check("midrst_read_in", 32'(rin[0]), 32'd1);
        check("midrst_valid_out", 32'(vout[0]), 32'd0);
        check("midrst_data_out", 32'(dout[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_word(0, 8'hA5, 2'b00, 0, 1'b0);

        run_word(0, 8'h80, 2'b10, 0, 1'b0);
        run_word(0, 8'h01, 2'b11, 0, 1'b1);
        run_word(0, 8'hF0, 2'b01, 0, 1'b1);
        run_word(1, 8'h5A, 2'b10, 0, 1'b0);
        run_word(1, 8'hA7, 2'b11, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_word(i % 2, 8'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
